// File: rtl/axi4_mem_responder_pkg.sv
// Shared types for the AXI4 memory responder: burst encodings, response codes
// and the read/write FSM state enums.
package axi4_mem_responder_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Combinational AXI4 next-beat address generator with request legality check.
// Illegal bursts (reserved type, bad WRAP length) are stepped as INCR.
module axi4_burst_addr_gen
    import axi4_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  req_err
);

    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    logic                  wrap_len_ok;
    burst_e                eff_burst;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        incr        = ADDR_WIDTH'(1) << size;
        wrap_mask   = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);

        eff_burst = burst_e'(burst);
        if ((burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok)) begin
            eff_burst = BURST_INCR;
        end

        case (eff_burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + incr) & wrap_mask);
            default:     next_addr = addr + incr;
        endcase

        req_err = (size > MAX_SIZE) || (burst == BURST_RSVD) ||
                  ((burst == BURST_WRAP) && !wrap_len_ok);
    end

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 slave endpoint backed by an internal word memory. Independent read and
// write FSMs share only the memory array; bad requests complete with SLVERR.
module axi4_mem_responder
    import axi4_mem_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    input  logic                    arvalid,
    output logic                    arready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LG     = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Borrow out of the subtraction flags addresses below the window.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] diff;
        diff = {1'b0, a} - {1'b0, BASE_ADDR};
        return !diff[ADDR_WIDTH] &&
               ((diff[ADDR_WIDTH-1:0] >> LG) < ADDR_WIDTH'(MEM_WORDS));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> LG);
    endfunction

    // Holds both address channels off until the first edge after reset release.
    logic live_reg;
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) live_reg <= 1'b0;
        else           live_reg <= 1'b1;
    end

    // ---------------- write path ----------------
    w_state_e              w_state_reg, w_state_next;
    logic [ID_WIDTH-1:0]   w_id_reg;
    logic [ADDR_WIDTH-1:0] w_addr_reg, w_next_addr;
    logic [7:0]            w_len_reg, w_cnt_reg;
    logic [2:0]            w_size_reg;
    logic [1:0]            w_burst_reg;
    logic                  w_err_reg;
    logic                  aw_fire, w_fire, w_beat_last, w_beat_err, w_req_err;

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_w_addr_gen (
        .addr      (w_addr_reg),
        .len       (w_len_reg),
        .size      (w_size_reg),
        .burst     (w_burst_reg),
        .next_addr (w_next_addr),
        .req_err   (w_req_err)
    );

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) w_state_reg <= W_IDLE;
        else           w_state_reg <= w_state_next;
    end

    always_comb begin
        w_state_next = w_state_reg;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                awready = live_reg;
                if (awvalid && live_reg) w_state_next = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_beat_last) w_state_next = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    assign aw_fire     = awvalid && awready;
    assign w_fire      = wvalid && wready;
    assign w_beat_last = (w_cnt_reg == w_len_reg);
    assign w_beat_err  = w_req_err || !in_range(w_addr_reg) || (wlast != w_beat_last);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_id_reg    <= '0;
            w_addr_reg  <= '0;
            w_len_reg   <= '0;
            w_size_reg  <= '0;
            w_burst_reg <= '0;
            w_cnt_reg   <= '0;
            w_err_reg   <= 1'b0;
        end else if (aw_fire) begin
            w_id_reg    <= awid;
            w_addr_reg  <= awaddr;
            w_len_reg   <= awlen;
            w_size_reg  <= awsize;
            w_burst_reg <= awburst;
            w_cnt_reg   <= '0;
            w_err_reg   <= 1'b0;
        end else if (w_fire) begin
            w_addr_reg <= w_next_addr;
            w_cnt_reg  <= w_cnt_reg + 8'd1;
            w_err_reg  <= w_err_reg | w_beat_err;
        end
    end

    always_ff @(posedge aclk) begin
        if (w_fire && in_range(w_addr_reg)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[word_idx(w_addr_reg)][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign bid   = w_id_reg;
    assign bresp = (bvalid && w_err_reg) ? SLVERR : OKAY;

    // ---------------- read path ----------------
    r_state_e              r_state_reg, r_state_next;
    logic [ID_WIDTH-1:0]   r_id_reg;
    logic [ADDR_WIDTH-1:0] r_addr_reg, r_gen_addr, r_next_addr, r_load_addr;
    logic [7:0]            r_len_reg, r_cnt_reg, r_gen_len;
    logic [2:0]            r_size_reg, r_gen_size;
    logic [1:0]            r_burst_reg, r_gen_burst;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;
    logic                  r_idle, ar_fire, r_fire, r_beat_last, r_load, r_req_err;

    // While idle the generator checks the incoming request so beat 0 gets its response.
    assign r_idle      = (r_state_reg == R_IDLE);
    assign r_gen_addr  = r_idle ? araddr  : r_addr_reg;
    assign r_gen_len   = r_idle ? arlen   : r_len_reg;
    assign r_gen_size  = r_idle ? arsize  : r_size_reg;
    assign r_gen_burst = r_idle ? arburst : r_burst_reg;

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_r_addr_gen (
        .addr      (r_gen_addr),
        .len       (r_gen_len),
        .size      (r_gen_size),
        .burst     (r_gen_burst),
        .next_addr (r_next_addr),
        .req_err   (r_req_err)
    );

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) r_state_reg <= R_IDLE;
        else           r_state_reg <= r_state_next;
    end

    always_comb begin
        r_state_next = r_state_reg;
        arready      = 1'b0;
        rvalid       = 1'b0;
        if (r_state_reg == R_IDLE) begin
            arready = live_reg;
            if (arvalid && live_reg) r_state_next = R_DATA;
        end else begin
            rvalid = 1'b1;
            if (rready && r_beat_last) r_state_next = R_IDLE;
        end
    end

    assign ar_fire     = arvalid && arready;
    assign r_fire      = rvalid && rready;
    assign r_beat_last = (r_cnt_reg == r_len_reg);
    assign r_load      = ar_fire || (r_fire && !r_beat_last);
    assign r_load_addr = r_idle ? araddr : r_next_addr;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_id_reg    <= '0;
            r_addr_reg  <= '0;
            r_len_reg   <= '0;
            r_size_reg  <= '0;
            r_burst_reg <= '0;
            r_cnt_reg   <= '0;
            rdata_reg   <= '0;
            rresp_reg   <= OKAY;
        end else begin
            if (ar_fire) begin
                r_id_reg    <= arid;
                r_len_reg   <= arlen;
                r_size_reg  <= arsize;
                r_burst_reg <= arburst;
                r_cnt_reg   <= '0;
            end else if (r_fire) begin
                r_cnt_reg <= r_cnt_reg + 8'd1;
            end
            if (r_load) begin
                r_addr_reg <= r_load_addr;
                rdata_reg  <= in_range(r_load_addr) ? mem[word_idx(r_load_addr)] : '0;
                rresp_reg  <= (r_req_err || !in_range(r_load_addr)) ? SLVERR : OKAY;
            end
        end
    end

    assign rid   = r_id_reg;
    assign rdata = rdata_reg;
    assign rresp = rresp_reg;
    assign rlast = rvalid && r_beat_last;

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed scoreboard bench: stimulus pushes expected B/R responses into queues,
// a negedge monitor pops and compares on every B/R handshake.
module tb_axi4_mem_responder;
    import axi4_mem_responder_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic          aclk = 1'b0;
    logic          areset_n = 1'b0;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [IW-1:0] awid, bid, arid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb;
    logic          arvalid, arready, rvalid, rready, rlast;

    axi4_mem_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_WORDS(1024), .BASE_ADDR('0)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t bq[$];
    r_exp_t rq[$];
    b_exp_t be;
    r_exp_t re;
    int applied = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        applied++;
        miscompares++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    always @(negedge aclk) begin
        if (areset_n) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    timeout_fail("b_unexpected");
                end else begin
                    be = bq.pop_front();
                    $display("B   id=%0h resp=%0b (exp id=%0h resp=%0b)", bid, bresp, be.id, be.resp);
                    chk("bid", 64'(bid), 64'(be.id));
                    chk("bresp", 64'(bresp), 64'(be.resp));
                end
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    timeout_fail("r_unexpected");
                end else begin
                    re = rq.pop_front();
                    $display("R   id=%0h data=%08h resp=%0b last=%0b (exp %0h %08h %0b %0b)",
                             rid, rdata, rresp, rlast, re.id, re.data, re.resp, re.last);
                    chk("rid", 64'(rid), 64'(re.id));
                    chk("rdata", 64'(rdata), 64'(re.data));
                    chk("rresp", 64'(rresp), 64'(re.resp));
                    chk("rlast", 64'(rlast), 64'(re.last));
                end
            end
        end
    end

    function automatic logic cur_ready(input int ch);
        case (ch)
            0:       return awready;
            1:       return wready;
            default: return arready;
        endcase
    endfunction

    // Returns #1 after the edge on which the handshake for channel ch occurs.
    task automatic wait_ready(input int ch);
        int n = 0;
        @(negedge aclk);
        while (!cur_ready(ch) && n < 100) begin
            n++;
            @(negedge aclk);
        end
        if (n >= 100) timeout_fail("ready_wait");
        @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin
            @(posedge aclk);
            n++;
        end
        if (n >= 200) begin
            timeout_fail("drain");
            bq.delete();
            rq.delete();
        end
        #1;
    endtask

    task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                               input logic [7:0] len, input logic [1:0] burst,
                               input logic [DW-1:0] d0, input logic [DW-1:0] step,
                               input logic [3:0] strb, input int early, input logic [1:0] eresp);
        bq.push_back('{id, eresp});
        awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
        wait_ready(0);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata  = d0 + step * DW'(b);
            wstrb  = strb;
            wlast  = (b == int'(len)) || (b == early);
            wvalid = 1'b1;
            wait_ready(1);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        drain();
    endtask

    task automatic exp_r(input logic [IW-1:0] id, input logic [DW-1:0] data,
                         input logic [1:0] resp, input logic last);
        rq.push_back('{id, data, resp, last});
    endtask

    task automatic exp_rseq(input logic [IW-1:0] id, input logic [DW-1:0] d0,
                            input logic [DW-1:0] step, input int len, input logic [1:0] resp);
        for (int b = 0; b <= len; b++) exp_r(id, d0 + step * DW'(b), resp, b == len);
    endtask

    task automatic read_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input int stall);
        rready = (stall == 0);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        wait_ready(2);
        arvalid = 1'b0;
        if (stall > 0) begin
            repeat (stall) @(posedge aclk);
            #1;
            rready = 1'b1;
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 1;

        // Reset and release
        areset_n = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        chk("reset_ctrl", 64'({awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp, bid, rid}), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        areset_n = 1'b1;
        @(negedge aclk);
        chk("ready_before_edge", 64'({awready, arready}), 64'd0);
        @(posedge aclk);
        #1;
        chk("ready_after_edge", 64'({awready, arready}), 64'b11);

        // INCR write and read-back with a stalled R channel
        write_burst(4'd5, 32'h10, 8'd3, 2'd1, 32'h11111111, 32'h11111111, 4'hF, -1, OKAY);
        exp_rseq(4'd9, 32'h11111111, 32'h11111111, 3, OKAY);
        read_burst(4'd9, 32'h10, 8'd3, 3'd2, 2'd1, 3);

        // WRAP read over words holding their own address
        write_burst(4'd1, 32'h30, 8'd3, 2'd1, 32'h30, 32'h4, 4'hF, -1, OKAY);
        exp_r(4'd2, 32'h38, OKAY, 1'b0);
        exp_r(4'd2, 32'h3C, OKAY, 1'b0);
        exp_r(4'd2, 32'h30, OKAY, 1'b0);
        exp_r(4'd2, 32'h34, OKAY, 1'b1);
        read_burst(4'd2, 32'h38, 8'd3, 3'd2, 2'd2, 0);

        // Byte strobes
        write_burst(4'd3, 32'h40, 8'd0, 2'd1, 32'h0, 32'h0, 4'hF, -1, OKAY);
        write_burst(4'd3, 32'h40, 8'd0, 2'd1, 32'hAABBCCDD, 32'h0, 4'b0101, -1, OKAY);
        exp_r(4'd3, 32'h00BB00DD, OKAY, 1'b1);
        read_burst(4'd3, 32'h40, 8'd0, 3'd2, 2'd1, 0);

        // Out-of-range write/read; word 0 must not be aliased
        write_burst(4'd0, 32'h0, 8'd0, 2'd1, 32'hCAFEF00D, 32'h0, 4'hF, -1, OKAY);
        write_burst(4'd6, 32'h1000, 8'd0, 2'd1, 32'h12345678, 32'h0, 4'hF, -1, SLVERR);
        exp_r(4'd7, 32'h0, SLVERR, 1'b1);
        read_burst(4'd7, 32'h1000, 8'd0, 3'd2, 2'd1, 0);
        exp_r(4'd7, 32'hCAFEF00D, OKAY, 1'b1);
        read_burst(4'd7, 32'h0, 8'd0, 3'd2, 2'd1, 0);

        // Reserved burst type: stepped as INCR, SLVERR on each beat
        exp_rseq(4'd4, 32'h11111111, 32'h11111111, 1, SLVERR);
        read_burst(4'd4, 32'h10, 8'd1, 3'd2, 2'd3, 0);

        // Early wlast: all four beats still written, bresp SLVERR
        write_burst(4'd8, 32'h50, 8'd3, 2'd1, 32'h1, 32'h1, 4'hF, 1, SLVERR);
        exp_rseq(4'd8, 32'h1, 32'h1, 3, OKAY);
        read_burst(4'd8, 32'h50, 8'd3, 3'd2, 2'd1, 0);

        // FIXED burst repeats the same word
        exp_rseq(4'd10, 32'h22222222, 32'h0, 1, OKAY);
        read_burst(4'd10, 32'h14, 8'd1, 3'd2, 2'd0, 0);

        // Oversized beat and illegal WRAP length both give SLVERR
        exp_r(4'd11, 32'h22222222, SLVERR, 1'b1);
        read_burst(4'd11, 32'h14, 8'd0, 3'd3, 2'd1, 0);
        exp_rseq(4'd12, 32'h30, 32'h4, 2, SLVERR);
        read_burst(4'd12, 32'h30, 8'd2, 3'd2, 2'd2, 0);

        // Mid-burst reset after beat 1 of a len=7 read
        write_burst(4'd2, 32'h60, 8'd7, 2'd1, 32'hA0000060, 32'h4, 4'hF, -1, OKAY);
        exp_r(4'd3, 32'hA0000060, OKAY, 1'b0);
        exp_r(4'd3, 32'hA0000064, OKAY, 1'b0);
        rready = 1'b1;
        arid = 4'd3; araddr = 32'h60; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
        wait_ready(2);
        arvalid = 1'b0;
        n = 0;
        while (rq.size() != 0 && n < 50) begin
            @(posedge aclk);
            n++;
        end
        if (n >= 50) timeout_fail("midreset_beats");
        #1;
        areset_n = 1'b0;
        #1;
        chk("midreset_rvalid", 64'(rvalid), 64'd0);
        chk("midreset_ctrl", 64'({awready, arready, wready, bvalid, rlast, rresp, rid}), 64'd0);
        chk("midreset_rdata", 64'(rdata), 64'd0);
        rq.delete();
        repeat (3) @(posedge aclk);
        #1;
        areset_n = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        exp_rseq(4'd3, 32'hA0000060, 32'h4, 7, OKAY);
        read_burst(4'd3, 32'h60, 8'd7, 3'd2, 2'd1, 0);

        repeat (3) @(posedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/axi4_mem_responder.md
# axi4_mem_responder

Synthesizable AXI4 slave (responder) with internal word-addressed memory. It terminates one master-side port of `axi4_safety_connector` (m00..m03) in place of a verification slave agent, giving the interconnect a real RTL endpoint for system simulation and FPGA bring-up. It supports FIXED/INCR/WRAP bursts, byte strobes, ID echo, and SLVERR signalling for bad requests. It has fully independent read and write paths.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, data width; power of two, 32..256
- ID_WIDTH, 4, AXI ID width as seen on the master-side ports
- MEM_WORDS, 1024, memory depth in DATA_WIDTH words
- BASE_ADDR, 0, byte address of word 0; aligned to DATA_WIDTH/8
- aclk  in  1  clock; all logic on the rising edge
- areset_n  in  1  asynchronous, active-low reset
- awvalid / arvalid  in  1  address valid
- awready / arready  out  1  address ready
- awid / arid  in  ID_WIDTH  transaction ID
- awaddr / araddr  in  ADDR_WIDTH  start byte address
- awlen / arlen  in  8  beats minus one
- awsize / arsize  in  3  log2 bytes per beat
- awburst / arburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte enables
- wlast  in  1  last write beat
- bvalid / rvalid  out  1  response valid
- bready / rready  in  1  response ready
- bid / rid  out  ID_WIDTH  echoed AW/AR ID
- bresp / rresp  out  2  00 OKAY, 10 SLVERR
- rdata  out  DATA_WIDTH  read data
- rlast  out  1  last read beat

## Operation
- Reset value of every output is 0. Memory contents are not reset.
- awready and arready rise on the first aclk edge after areset_n is released.
- Word index = (addr − BASE_ADDR) >> log2(DATA_WIDTH/8).
- A beat is out of range if the address is below BASE_ADDR or the index is ≥ MEM_WORDS.
- Write FSM has three states: W_IDLE (awready=1), W_DATA (wready=1), and W_RESP (bvalid=1).
  - AW handshake: latch id, addr, len, size, burst; clear the beat counter and the error flag; move to W_DATA.
  - W handshake: write the bytes enabled by wstrb into the current word; advance the address; increment the counter.
  - When the counter reaches len, move to W_RESP.
  - B handshake returns the FSM to W_IDLE.
- wready stays low until AW is accepted. There is no W buffering.
- Read FSM has two states: R_IDLE (arready=1) and R_DATA (rvalid=1, rdata held in a register).
  - AR handshake: latch the request and load the first word into the rdata register.
  - Each R handshake: load the next word.
  - rlast = (counter == len). The beat with rlast returns the FSM to R_IDLE.
- rdata, rresp, rid, and rlast are stable while rvalid=1 and rready=0.
- Address generation is identical for both paths, with increment = 1 << size:
  - FIXED: address unchanged.
  - INCR: address + increment.
  - WRAP: boundary mask = ((len+1) << size) − 1; next = (addr & ~mask) | ((addr + increment) & mask).
- Error cases and responses:
  - Out-of-range beat: write is dropped; read returns 0. The transaction is flagged SLVERR.
  - Request errors: size > log2(DATA_WIDTH/8), burst=3 (processed as INCR), or WRAP with len not in {1,3,7,15} (processed as INCR). All give SLVERR.
  - wlast mismatch: wlast asserted early, or absent on the final beat. Gives SLVERR. Beat count is governed by len only.
  - bresp is SLVERR if any beat erred. rresp is computed per beat.
- Narrow transfers use the full-width word at the current index. Lane selection is the master's responsibility via wstrb.
- Same-cycle read load and write to the same word: the read returns the old data.

## Timing
- AW handshake at cycle N: wready=1 from N+1.
- Last W beat at cycle M: bvalid=1 at M+1.
- B handshake at cycle K: awready=1 at K+1.
- AR handshake at cycle N: rvalid=1 with beat 0 at N+1. Beats are back-to-back while rready=1.
- Last R handshake at cycle K: arready=1 at K+1.
- Read and write paths never stall each other.
- Reset asserted mid-burst: both FSMs go idle immediately and all outputs go to 0. The outstanding transaction is discarded with no response. Memory writes already committed are kept.

## Structure
- Package axi4_mem_responder_pkg holds:
  - the burst enum (FIXED/INCR/WRAP/RSVD);
  - response constants OKAY=2'b00 and SLVERR=2'b10;
  - the FSM state enums.
- Sub-module axi4_burst_addr_gen: combinational next-address and wrap-legality logic, instantiated once per path.
- The memory is one array declared in the top module, written by the W path and read by the R path.

## Test plan
- Reset: hold areset_n low for 5 cycles → all outputs 0; awready=arready=1 one edge after release.
- INCR: write len=3, size=2, addr 0x10, data 0x11111111..0x44444444, wstrb 4'hF, awid 5 → bid=5, bresp 00. Read back with arid 9 → 4 beats in order, rlast on beat 3 only, rid=9, rresp 00.
- WRAP: memory preset so each word holds its address. Read len=3, size=2, addr 0x38 → rdata 0x38, 0x3C, 0x30, 0x34.
- Strobes: word 0x40 = 0. Write 0xAABBCCDD with wstrb 4'b0101 → read returns 0x00BB00DD.
- Errors, all → SLVERR:
  - write to BASE_ADDR + MEM_WORDS*4 → bresp 10, memory unchanged;
  - read at the same address → rdata 0, rresp 10;
  - arburst=3 → rresp 10;
  - wlast asserted on beat 1 of a len=3 burst → 4 beats accepted, bresp 10.
- Mid-burst reset: assert areset_n low after beat 1 of a len=7 read → rvalid=0 asynchronously. After release, a new read of the same address returns the correct data.
